// File: rtl/cic_adpcm_pkg.sv
// Shared types and default constants for the CIC/ADPCM sequencer slice.
package cic_adpcm_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_WARMUP = 3'd2,
    S_RUN    = 3'd3,
    S_FLUSH  = 3'd4
  } state_t;

  localparam int DEF_DECIM      = 64;
  localparam int DEF_ADPCM_DIV  = 8;
  localparam int DEF_WARMUP     = 4;
  localparam int DEF_FIFO_DEPTH = 8;

  localparam int NIB_W  = 4;
  localparam int BYTE_W = 8;

endpackage

// File: rtl/cic_adpcm_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO is taken only when a pop frees a slot that cycle.
module cic_adpcm_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             push_ok
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign push_ok = do_push;

  // Empty reads as zero so the output is defined without resetting storage
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cic_adpcm_ctrl.sv
// Start-up/shut-down sequencer for the CIC + ADPCM chain: clear pulse, CIC gating,
// ADPCM tick, warm-up discard, nibble packing into a byte FIFO, stall watchdog.
module cic_adpcm_ctrl
  import cic_adpcm_pkg::*;
#(
  parameter int DECIM      = DEF_DECIM,
  parameter int ADPCM_DIV  = DEF_ADPCM_DIV,
  parameter int WARMUP     = DEF_WARMUP,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  output logic                    cic_ce,
  output logic                    adpcm_tick,
  output logic                    adpcm_clr,
  input  logic                    enc_valid,
  input  logic signed [NIB_W-1:0] enc_pcm,
  output logic [BYTE_W-1:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    overflow,
  output logic                    stall_err,
  output logic                    busy
);

  localparam int TW     = (ADPCM_DIV > 1) ? $clog2(ADPCM_DIV) : 1;
  localparam int WU_W   = $clog2(WARMUP + 2);
  localparam int WD_MAX = 2 * DECIM;
  localparam int WD_W   = $clog2(WD_MAX + 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [TW-1:0]           tick_cnt;
  logic [WU_W-1:0]         wu_cnt;
  logic [WD_W-1:0]         wd_cnt;
  logic                    pending;
  logic signed [NIB_W-1:0] low_nib;
  logic                    wu_last;
  logic                    code_run;
  logic                    push_req;
  logic [BYTE_W-1:0]       push_byte;
  logic                    push_ok;
  logic                    fifo_empty;

  assign wu_last    = (wu_cnt == WU_W'(WARMUP - 1));
  assign code_run   = (state == S_RUN) && enc_valid;
  assign adpcm_tick = cic_ce && (tick_cnt == TW'(ADPCM_DIV - 1));
  assign out_valid  = ~fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // CLEAR ignores enable so the predictor clear always completes
  always_comb begin
    state_nxt = state;
    cic_ce    = 1'b0;
    adpcm_clr = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (enable) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        adpcm_clr = 1'b1;
        state_nxt = (WARMUP == 0) ? S_RUN : S_WARMUP;
      end
      S_WARMUP: begin
        cic_ce = 1'b1;
        if (!enable)                  state_nxt = S_FLUSH;
        else if (enc_valid && wu_last) state_nxt = S_RUN;
      end
      S_RUN: begin
        cic_ce = 1'b1;
        if (!enable) state_nxt = S_FLUSH;
      end
      S_FLUSH: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Second code of a pair completes a byte; an odd trailing code is zero-padded on flush
  always_comb begin
    push_req  = 1'b0;
    push_byte = '0;
    if (code_run && pending) begin
      push_req  = 1'b1;
      push_byte = {enc_pcm, low_nib};
    end else if ((state == S_FLUSH) && pending) begin
      push_req  = 1'b1;
      push_byte = {{NIB_W{1'b0}}, low_nib};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt  <= '0;
      wu_cnt    <= '0;
      wd_cnt    <= '0;
      pending   <= 1'b0;
      overflow  <= 1'b0;
      stall_err <= 1'b0;
    end else begin
      if (!cic_ce || adpcm_tick) tick_cnt <= '0;
      else                       tick_cnt <= tick_cnt + 1'b1;

      if (state == S_CLEAR)                     wu_cnt <= '0;
      else if ((state == S_WARMUP) && enc_valid) wu_cnt <= wu_cnt + 1'b1;

      if ((state == S_CLEAR) || (state == S_FLUSH)) pending <= 1'b0;
      else if (code_run)                            pending <= ~pending;

      // Held at zero outside RUN, so entering RUN starts a fresh window
      if ((state != S_RUN) || enc_valid)    wd_cnt <= '0;
      else if (wd_cnt != WD_W'(WD_MAX))     wd_cnt <= wd_cnt + 1'b1;

      if (state == S_CLEAR)
        stall_err <= 1'b0;
      else if ((state == S_RUN) && !enc_valid && (wd_cnt == WD_W'(WD_MAX - 1)))
        stall_err <= 1'b1;

      if (state == S_CLEAR)         overflow <= 1'b0;
      else if (push_req && !push_ok) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (code_run && !pending) low_nib <= enc_pcm;
  end

  cic_adpcm_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_req),
    .push_data (push_byte),
    .pop       (out_valid & out_ready),
    .pop_data  (out_data),
    .empty     (fifo_empty),
    .push_ok   (push_ok)
  );

endmodule

// File: tb/tb_cic_adpcm_ctrl.sv
// Directed + randomized bench for cic_adpcm_ctrl with a code-list-to-byte-list reference model.
module tb_cic_adpcm_ctrl;

  localparam int DECIM      = 64;
  localparam int ADPCM_DIV  = 8;
  localparam int WARMUP     = 4;
  localparam int FIFO_DEPTH = 8;

  logic              clk;
  logic              rst_n;
  logic              enable;
  logic              cic_ce;
  logic              adpcm_tick;
  logic              adpcm_clr;
  logic              enc_valid;
  logic signed [3:0] enc_pcm;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;
  logic              overflow;
  logic              stall_err;
  logic              busy;

  cic_adpcm_ctrl #(
    .DECIM      (DECIM),
    .ADPCM_DIV  (ADPCM_DIV),
    .WARMUP     (WARMUP),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .cic_ce     (cic_ce),
    .adpcm_tick (adpcm_tick),
    .adpcm_clr  (adpcm_clr),
    .enc_valid  (enc_valid),
    .enc_pcm    (enc_pcm),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overflow   (overflow),
    .stall_err  (stall_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks   = 0;
  int         failures = 0;
  bit         rand_ready = 0;
  logic [3:0] tx_codes[$];
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  int         tpos[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Records every byte the consumer accepts at the coming edge, then advances one cycle
  task automatic tick();
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    if (out_valid && out_ready) rx_q.push_back(out_data);
    @(posedge clk);
    #1;
  endtask

  task automatic send_code(input logic [3:0] c, input int gap);
    tx_codes.push_back(c);
    enc_valid = 1'b1;
    enc_pcm   = c;
    tick();
    enc_valid = 1'b0;
    repeat (gap - 1) tick();
  endtask

  task automatic start_session();
    tx_codes.delete();
    rx_q.delete();
    enable = 1'b1;
    tick();
    tick();
  endtask

  task automatic stop_session();
    enable = 1'b0;
    tick();
    tick();
  endtask

  task automatic drain();
    rand_ready = 0;
    out_ready  = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (!out_valid) break;
      tick();
    end
    check("drain_empty", out_valid, 1'b0);
  endtask

  // Reference: drop the warm-up codes, pair the rest low-first, zero-pad an odd tail
  task automatic compute_exp();
    int idx;
    exp_q.delete();
    idx = WARMUP;
    while (idx + 1 < tx_codes.size()) begin
      exp_q.push_back({tx_codes[idx+1], tx_codes[idx]});
      idx += 2;
    end
    if (idx < tx_codes.size()) exp_q.push_back({4'h0, tx_codes[idx]});
  endtask

  task automatic compare_rx(input string tag, input int n);
    logic [7:0] obs;
    check({tag, "_count"}, rx_q.size(), n);
    for (int i = 0; i < n; i++) begin
      obs = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      check($sformatf("%s_byte%0d", tag, i), obs, exp_q[i]);
    end
  endtask

  initial begin
    int clr_extra;
    int first_t;
    int period_t;
    int n_codes;
    logic [3:0] c;

    rst_n = 1'b0; enable = 1'b0; enc_valid = 1'b0; enc_pcm = 4'h0; out_ready = 1'b0;
    repeat (3) tick();
    check("rst_cic_ce", cic_ce, 1'b0);
    check("rst_tick", adpcm_tick, 1'b0);
    check("rst_clr", adpcm_clr, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_stall", stall_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick();

    // Start-up: clear pulse, CE two cycles after enable, tick cadence
    tx_codes.delete(); rx_q.delete();
    out_ready = 1'b1;
    enable = 1'b1;
    tick();
    check("start_clr_hi", adpcm_clr, 1'b1);
    check("start_ce_lo", cic_ce, 1'b0);
    check("start_busy", busy, 1'b1);
    tick();
    check("start_clr_lo", adpcm_clr, 1'b0);
    check("start_ce_hi", cic_ce, 1'b1);
    clr_extra = 0;
    tpos.delete();
    for (int i = 0; i < 20; i++) begin
      if (adpcm_tick) tpos.push_back(i);
      if (adpcm_clr) clr_extra++;
      tick();
    end
    first_t  = (tpos.size() > 0) ? tpos[0] : -1;
    period_t = (tpos.size() > 1) ? tpos[1] - tpos[0] : -1;
    check("tick_first", first_t, ADPCM_DIV - 1);
    check("tick_period", period_t, ADPCM_DIV);
    check("tick_count", tpos.size(), 2);
    check("clr_single", clr_extra, 0);

    // Warm-up discard and packing of codes 1..8
    for (int k = 1; k <= 8; k++) send_code(4'(k), DECIM);
    check("pack_no_stall", stall_err, 1'b0);
    stop_session();
    check("pack_idle", busy, 1'b0);
    drain();
    compute_exp();
    compare_rx("pack", 2);
    check("pack_first_const", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'h65);

    // Odd number of codes flushed with zero-padded high nibble
    start_session();
    for (int k = 0; k < WARMUP; k++) send_code(4'($urandom_range(0, 15)), 8);
    send_code(4'd3, 8);
    send_code(4'hE, 8);
    send_code(4'd5, 8);
    stop_session();
    check("odd_idle", busy, 1'b0);
    drain();
    compute_exp();
    compare_rx("odd", 2);
    check("odd_last_const", (rx_q.size() > 1) ? rx_q[1] : 8'hxx, 8'h05);

    // Randomized sessions with random consumer stalls
    for (int s = 0; s < 3; s++) begin
      rand_ready = 1;
      start_session();
      n_codes = WARMUP + $urandom_range(5, 15);
      for (int k = 0; k < n_codes; k++)
        send_code(4'($urandom_range(0, 15)), $urandom_range(2, 20));
      stop_session();
      drain();
      compute_exp();
      compare_rx($sformatf("rand%0d", s), exp_q.size());
      check($sformatf("rand%0d_ovf", s), overflow, 1'b0);
    end

    // Fill to 8 bytes, push+pop on full, then a dropped 10th byte
    out_ready = 1'b0;
    start_session();
    for (int k = 0; k < WARMUP + 16; k++) send_code(4'($urandom_range(0, 15)), 2);
    check("full_ovf0", overflow, 1'b0);
    check("full_valid", out_valid, 1'b1);
    send_code(4'($urandom_range(0, 15)), 2);
    c = 4'($urandom_range(0, 15));
    tx_codes.push_back(c);
    enc_valid = 1'b1;
    enc_pcm   = c;
    out_ready = 1'b1;
    tick();
    enc_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    check("pushpop_ovf0", overflow, 1'b0);
    check("pushpop_popped", rx_q.size(), 1);
    send_code(4'($urandom_range(0, 15)), 2);
    send_code(4'($urandom_range(0, 15)), 2);
    check("drop_ovf1", overflow, 1'b1);
    stop_session();
    check("ovf_sticky_idle", overflow, 1'b1);
    drain();
    compute_exp();
    compare_rx("bp", 9);

    // Restart clears overflow; then stall the code stream
    out_ready = 1'b0;
    start_session();
    check("restart_ovf_clr", overflow, 1'b0);
    for (int k = 0; k < WARMUP; k++) send_code(4'($urandom_range(0, 15)), 4);
    send_code(4'($urandom_range(0, 15)), 1);
    send_code(4'($urandom_range(0, 15)), 1);
    repeat (120) tick();
    check("stall_early", stall_err, 1'b0);
    repeat (20) tick();
    check("stall_set", stall_err, 1'b1);
    check("stall_busy", busy, 1'b1);
    check("stall_ce", cic_ce, 1'b1);
    check("stall_fifo", out_valid, 1'b1);

    // Asynchronous reset mid-RUN
    rst_n = 1'b0;
    #1;
    check("arst_valid", out_valid, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_ce", cic_ce, 1'b0);
    check("arst_stall", stall_err, 1'b0);
    check("arst_data", out_data, 8'h00);
    enable = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("arst_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cic_adpcm_ctrl.md
# cic_adpcm_ctrl

Sequencer for the CIC decimator + ADPCM encoder datapath. Owns start-up and shut-down of the chain: clears the ADPCM predictor, gates the CIC and generates the ADPCM clock-enable tick in place of a derived slow clock. It discards warm-up samples, packs 4-bit ADPCM codes into bytes and buffers them in a small FIFO behind a valid/ready output. It sits between the block-level enable and the CIC/ADPCM wrapper on one side and the downstream byte consumer on the other.

## Interface
- DECIM, 64: clk cycles per decimated sample; watchdog base
- ADPCM_DIV, 8: clk cycles per adpcm_tick
- WARMUP, 4: number of enc_valid codes discarded after start (0 allowed)
- FIFO_DEPTH, 8: output FIFO depth in bytes, power of two

Ports:
- clk  in  1  single system clock (PDM bit clock); all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  level request to run the chain
- cic_ce  out  1  CIC clock-enable; high in WARMUP and RUN
- adpcm_tick  out  1  one-cycle strobe every ADPCM_DIV clk while cic_ce
- adpcm_clr  out  1  one-cycle predictor/step-index clear pulse
- enc_valid  in  1  datapath code strobe (wrapper outValid)
- enc_pcm  in  4  signed ADPCM code (wrapper encPcm)
- out_data  out  8  packed byte, first code in [3:0], second in [7:4]
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts out_data when out_valid & out_ready
- overflow  out  1  sticky: byte dropped on full FIFO
- stall_err  out  1  sticky: no enc_valid for 2*DECIM cycles in RUN
- busy  out  1  state != IDLE

## Operation
- States: IDLE, CLEAR, WARMUP, RUN, FLUSH.
- IDLE: cic_ce=0, tick counter held at 0. enable=1 -> CLEAR.
- CLEAR: exactly one cycle. adpcm_clr=1; overflow, stall_err, nibble-pending flag, warm-up counter and watchdog cleared. -> WARMUP, or RUN if WARMUP=0.
- WARMUP: cic_ce=1; count enc_valid. Codes are discarded. After the WARMUP-th code -> RUN; that code is also discarded.
- RUN: cic_ce=1.
  - On enc_valid with nibble pending clear: latch enc_pcm into the low nibble and set pending.
  - On enc_valid with pending set: push {enc_pcm, low} to the FIFO and clear pending.
- enable=0 in WARMUP or RUN -> FLUSH, which lasts one cycle.
  - If pending: push {4'b0, low} and clear pending.
  - An enc_valid arriving in FLUSH is ignored.
  - -> IDLE.
- enable=0 in CLEAR has no effect: CLEAR always completes, then WARMUP evaluates enable.
- adpcm_tick: a mod-ADPCM_DIV counter runs only while cic_ce. Tick fires when the counter = ADPCM_DIV-1. The counter resets to 0 in CLEAR and IDLE.
- Watchdog (RUN only): the counter resets on every enc_valid and on entry to RUN. Reaching 2*DECIM sets stall_err; the state is unchanged.
- FIFO push is accepted if not full, or if a pop occurs in the same cycle. Otherwise the byte is dropped and overflow is set.
- Pop occurs on out_valid & out_ready. The FIFO drains in every state, including IDLE.

## Timing
- Reset: state IDLE. All outputs 0 (out_data 8'h00). FIFO empty, counters 0.
- enable rises at cycle N: CLEAR at N+1 (adpcm_clr high). cic_ce high from N+2.
- First adpcm_tick at N+2+ADPCM_DIV-1, then every ADPCM_DIV cycles.
- Push at cycle P: out_valid high and out_data valid at P+1. FIFO is first-word-fall-through, with registered flags.
- Simultaneous push and pop on a full FIFO: both occur, count unchanged, no overflow.
- Simultaneous push and pop on an empty FIFO: the push is stored; out_valid goes high next cycle.
- rst_n asserted mid-operation: immediate return to reset values. FIFO contents and the pending nibble are lost.
- enc_valid is sampled only in WARMUP and RUN.

## Structure
- Package cic_adpcm_pkg holds:
  - the state enum (state_t) and its encodings;
  - default parameter constants: DECIM, ADPCM_DIV, WARMUP, FIFO_DEPTH;
  - the nibble/byte width constants.
- Sub-module cic_adpcm_fifo: synchronous FIFO with parameterised width/depth, FWFT, full/empty, same-cycle push/pop.
- The FSM, tick divider, warm-up counter, packer and watchdog live in the top module.

## Test plan
- Reset/start: hold rst_n=0 and check all outputs 0. Release, raise enable. Check:
  - adpcm_clr is a single pulse;
  - cic_ce is high 2 cycles after enable;
  - adpcm_tick period is exactly 8.
- Warm-up + packing (WARMUP=4): send codes 1..8 on enc_valid every 64 cycles -> bytes 8'h65, 8'h87 appear; codes 1-4 do not.
- Odd flush: in RUN send codes 3, -2, 5, then drop enable -> bytes 8'hE3, 8'h05; return to IDLE, busy=0.
- Backpressure/overflow: hold out_ready=0 and push 9 bytes -> 8 are retained and overflow=1. Then set out_ready=1 -> the 8 bytes drain in order. Restart -> overflow clears in CLEAR.
- Full FIFO with simultaneous push and pop -> count stays 8, overflow stays 0.
- Stall and async reset: in RUN, stop enc_valid -> stall_err=1 at 128 cycles after the last code. Assert rst_n mid-RUN -> out_valid=0 and state IDLE immediately.
